// File: rtl/fifo_stream_reader.sv
// Read-side engine for a byte FIFO: pops entries on credit and re-presents them as a valid/ready stream.
// Latency: RD_LAT+1 clks from the first fifo_rd_en to m_valid; sustains 1 byte/clk once primed.
// Backpressure: m_ready low fills the skid, and fetching stalls when occ+inflight reaches SKID_DEPTH.
module fifo_stream_reader #(
   parameter int DW         = 8,
   parameter int RD_LAT     = 1,
   parameter int SKID_DEPTH = 4,
   parameter int CW         = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          fifo_empty,
   input  logic [DW-1:0] fifo_dout,
   output logic          fifo_rd_en,
   output logic          m_valid,
   output logic [DW-1:0] m_data,
   input  logic          m_ready,
   output logic          busy,
   output logic [CW-1:0] rd_count
);

   localparam int PW   = $clog2(SKID_DEPTH);
   localparam int OW   = $clog2(SKID_DEPTH + 1);
   localparam int CNTW = $clog2(SKID_DEPTH + RD_LAT + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [RD_LAT-1:0] lat_q;
   logic [DW-1:0]   skid_q [SKID_DEPTH];
   logic [PW-1:0]   head_q, tail_q;
   logic [OW-1:0]   occ_q, occ_d;
   logic [CW-1:0]   rd_count_q;

   logic            land;
   logic            pop;
   logic [CNTW-1:0] inflight;
   logic            credit_ok;

   // Count issued-but-not-landed reads and derive the fetch credit from registered state only.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         inflight = inflight + CNTW'(lat_q[i]);
      end
      credit_ok  = (CNTW'(occ_q) + inflight) < CNTW'(SKID_DEPTH);
      fifo_rd_en = (state_q == RUN) && !fifo_empty && credit_ok;
   end

   assign land     = lat_q[RD_LAT-1];
   assign m_valid  = (occ_q != '0);
   assign pop      = m_valid && m_ready;
   assign m_data   = skid_q[head_q];
   assign busy     = (state_q != IDLE);
   assign rd_count = rd_count_q;

   // Next-state logic; re-enable in STOP wins over the drain-complete exit.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (en) state_d = RUN;
         RUN:  if (!en) state_d = STOP;
         STOP: begin
            if (en) begin
               state_d = RUN;
            end else if ((inflight == '0) && (occ_q == '0)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Occupancy moves by +1 on land, -1 on pop, unchanged when both happen together.
   always_comb begin
      occ_d = occ_q;
      if (land && !pop) begin
         occ_d = occ_q + OW'(1);
      end else if (!land && pop) begin
         occ_d = occ_q - OW'(1);
      end
   end

   // State register and read-latency shift line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         lat_q   <= '0;
      end else begin
         state_q <= state_d;
         lat_q   <= RD_LAT'({lat_q, fifo_rd_en});
      end
   end

   // Skid ring buffer: landings write the tail, pops advance the head, contents cleared on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SKID_DEPTH; i++) begin
            skid_q[i] <= '0;
         end
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
      end else begin
         if (land) begin
            skid_q[tail_q] <= fifo_dout;
            tail_q <= (tail_q == PW'(SKID_DEPTH - 1)) ? '0 : tail_q + PW'(1);
         end
         if (pop) begin
            head_q <= (head_q == PW'(SKID_DEPTH - 1)) ? '0 : head_q + PW'(1);
         end
         occ_q <= occ_d;
      end
   end

   // Delivered-byte counter, wraps naturally at 2^CW.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_count_q <= '0;
      end else if (pop) begin
         rd_count_q <= rd_count_q + CW'(1);
      end
   end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural 1-clk-latency FIFO feeding the DUT, scoreboard on the stream.
// Expected bytes are queued at preload time; a negedge monitor pops and compares on every handshake.
// Directed scenarios: reset, streaming, backpressure, stop, empty FIFO, asynchronous mid-run reset.
module tb_fifo_stream_reader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       fifo_empty = 1'b1;
   logic [7:0] fifo_dout = 8'h00;
   logic       fifo_rd_en;
   logic       m_valid;
   logic [7:0] m_data;
   logic       m_ready = 1'b0;
   logic       busy;
   logic [15:0] rd_count;

   logic [7:0] fq[$];
   logic [7:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;
   int rd_pulses = 0;
   int cyc = 0;
   int first_pop = -1;
   int last_pop = -1;

   fifo_stream_reader #(.DW(8), .RD_LAT(1), .SKID_DEPTH(4), .CW(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .fifo_empty (fifo_empty),
      .fifo_dout  (fifo_dout),
      .fifo_rd_en (fifo_rd_en),
      .m_valid    (m_valid),
      .m_data     (m_data),
      .m_ready    (m_ready),
      .busy       (busy),
      .rd_count   (rd_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [7:0] b);
      fq.push_back(b);
      exp_q.push_back(b);
   endtask

   // Behavioural FIFO: read data appears one clk after the pop strobe, empty flag is registered.
   always @(posedge clk) begin
      cyc++;
      if (fifo_rd_en) begin
         rd_pulses++;
         n_cmp++;
         if (fq.size() == 0) begin
            n_err++;
            $display("FAIL fifo_underflow: rd_en while FIFO empty at cycle %0d", cyc);
         end else begin
            fifo_dout <= fq.pop_front();
         end
      end
      fifo_empty <= (fq.size() == 0);
   end

   // Stream monitor: every accepted beat must match the next expected byte.
   always @(negedge clk) begin
      if (!rst && m_valid && m_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_beat: got 0x%0h, expected no data", m_data);
         end else begin
            check("m_data", {24'h0, m_data}, {24'h0, exp_q.pop_front()});
         end
         if (first_pop < 0) first_pop = cyc;
         last_pop = cyc;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      int vcnt;

      // Reset values
      tick(3);
      check("rst_rd_en", fifo_rd_en, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_rd_count", rd_count, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      tick(2);

      // Streaming 0x11..0x88 with m_ready=1
      for (int i = 1; i <= 8; i++) preload(8'(i * 17));
      m_ready = 1'b1;
      tick(1);
      rd_pulses = 0;
      first_pop = -1;
      en = 1'b1;
      tick(16);
      check("stream_rd_pulses", rd_pulses, 8);
      check("stream_left", exp_q.size(), 0);
      check("stream_consecutive", last_pop - first_pop, 7);
      check("stream_rd_count", rd_count, 8);
      en = 1'b0;
      tick(4);
      check("stream_idle", busy, 0);

      // Backpressure: 4 reads fill the skid, head held
      for (int i = 1; i <= 8; i++) preload(8'(i * 17));
      m_ready = 1'b0;
      tick(1);
      rd_pulses = 0;
      en = 1'b1;
      tick(10);
      check("bp_rd_pulses", rd_pulses, 4);
      check("bp_m_valid", m_valid, 1);
      check("bp_m_data_held", m_data, 8'h11);
      check("bp_pending", exp_q.size(), 8);
      m_ready = 1'b1;
      tick(12);
      check("bp_rd_pulses_total", rd_pulses, 8);
      check("bp_left", exp_q.size(), 0);
      check("bp_rd_count", rd_count, 16);
      en = 1'b0;
      tick(4);

      // Stop right after the first read is issued
      for (int i = 1; i <= 8; i++) preload(8'(i * 17));
      m_ready = 1'b1;
      tick(1);
      rd_pulses = 0;
      en = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (fifo_rd_en) found = 1'b1;
      end
      en = 1'b0;
      check("stop_rd_seen", found, 1);
      tick(8);
      check("stop_rd_pulses", rd_pulses, 1);
      check("stop_left", exp_q.size(), 7);
      check("stop_busy", busy, 0);
      check("stop_rd_count", rd_count, 17);
      fq.delete();
      exp_q.delete();
      tick(2);

      // Empty FIFO with en=1
      rd_pulses = 0;
      vcnt = 0;
      en = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (m_valid) vcnt++;
      end
      check("empty_rd_pulses", rd_pulses, 0);
      check("empty_valid_cycles", vcnt, 0);
      en = 1'b0;
      tick(3);

      // Asynchronous reset with 3 bytes held in the skid
      preload(8'h5A);
      preload(8'h6B);
      preload(8'h7C);
      m_ready = 1'b0;
      tick(1);
      en = 1'b1;
      tick(10);
      check("ar_pre_valid", m_valid, 1);
      check("ar_pre_data", m_data, 8'h5A);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("ar_m_valid", m_valid, 0);
      check("ar_m_data", m_data, 0);
      check("ar_rd_en", fifo_rd_en, 0);
      check("ar_busy", busy, 0);
      check("ar_rd_count", rd_count, 0);
      exp_q.delete();
      en = 1'b0;
      tick(2);
      rst = 1'b0;
      preload(8'hC3);
      preload(8'hD4);
      m_ready = 1'b1;
      tick(1);
      en = 1'b1;
      tick(10);
      check("ar_post_left", exp_q.size(), 0);
      check("ar_post_rd_count", rd_count, 2);
      en = 1'b0;
      tick(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
